// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Requests are granted round-robin, executed one at a time, and answered on a per-port response channel.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [CODE_WIDTH-1:0] req_code0,
  input  logic [CODE_WIDTH-1:0] req_code1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy
);

  localparam logic [CODE_WIDTH-1:0] ALU_ADD = CODE_WIDTH'(4'h0);
  localparam logic [CODE_WIDTH-1:0] ALU_SLL = CODE_WIDTH'(4'h1);
  localparam logic [CODE_WIDTH-1:0] ALU_SLT = CODE_WIDTH'(4'h2);
  localparam logic [CODE_WIDTH-1:0] ALU_XOR = CODE_WIDTH'(4'h4);
  localparam logic [CODE_WIDTH-1:0] ALU_SRL = CODE_WIDTH'(4'h5);
  localparam logic [CODE_WIDTH-1:0] ALU_OR  = CODE_WIDTH'(4'h6);
  localparam logic [CODE_WIDTH-1:0] ALU_AND = CODE_WIDTH'(4'h7);
  localparam logic [CODE_WIDTH-1:0] ALU_SUB = CODE_WIDTH'(4'h8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  last_grant;
  logic                  owner;
  logic                  grant;
  logic                  grant_any;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] op_a_p0;
  logic [DATA_WIDTH-1:0] op_b_p0;
  logic [CODE_WIDTH-1:0] op_code_p0;
  logic [DATA_WIDTH-1:0] alu_out;

  function automatic logic [DATA_WIDTH-1:0] alu_eval(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [CODE_WIDTH-1:0] code
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (code)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_AND: r = a & b;
      ALU_SLT: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Round-robin: on a tie the port that did not win last time goes first.
  always_comb begin
    grant_any = |req_valid;
    grant     = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst && grant_any) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) begin
        last_grant <= grant;
        owner      <= grant;
      end
    end
  end

  // Stage p0: operands captured at the request handshake.
  always_ff @(posedge clk) begin
    if (handshake) begin
      op_a_p0    <= grant ? req_a1    : req_a0;
      op_b_p0    <= grant ? req_b1    : req_b0;
      op_code_p0 <= grant ? req_code1 : req_code0;
    end
  end

  assign alu_out = alu_eval(op_a_p0, op_b_p0, op_code_p0);

  // Stage p1: ALU result registered in EXEC and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data <= '0;
    end else if (state == EXEC) begin
      resp_data <= alu_out;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (state == RESP) begin
      resp_valid[owner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each completed response handshake.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  localparam logic [CW-1:0] C_ADD = 4'h0;
  localparam logic [CW-1:0] C_SLL = 4'h1;
  localparam logic [CW-1:0] C_SLT = 4'h2;
  localparam logic [CW-1:0] C_XOR = 4'h4;
  localparam logic [CW-1:0] C_SRL = 4'h5;
  localparam logic [CW-1:0] C_SUB = 4'h8;
  localparam logic [CW-1:0] C_BAD = 4'hF;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [CW-1:0] req_code0, req_code1;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [DW-1:0] resp_data;
  logic          busy;

  typedef struct {
    logic          p;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_share_arbiter #(.DATA_WIDTH(DW), .CODE_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .req_code0  (req_code0),
    .req_code1  (req_code1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp port=%0d actual=%h required=none", i, resp_data);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_port", 32'(i), 32'(e.p));
            chk("resp_data", resp_data, e.d);
          end
        end
      end
    end
  end

  task automatic set_port(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [CW-1:0] code);
    if (p == 0) begin
      req_a0 = a; req_b0 = b; req_code0 = code; req_valid[0] = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_code1 = code; req_valid[1] = 1'b1;
    end
  endtask

  // Call just after a posedge; returns just after the posedge that completed the handshake.
  task automatic do_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] code, input bit push, input logic [DW-1:0] exp);
    bit ok;
    exp_t e;
    ok = 1'b0;
    if (push) begin
      e.p = p[0]; e.d = exp;
      q.push_back(e);
    end
    set_port(p, a, b, code);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL req_timeout port=%0d actual=no_ready required=ready", p);
    end else begin
      chk("req_ready_onehot", 32'(req_ready), (p == 0) ? 32'h1 : 32'h2);
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
    end
  endtask

  initial begin
    int grants;
    int last_cyc;
    int expp;
    bit ok;
    exp_t e;

    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_code0 = '0; req_code1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_resp_data", resp_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie fairness straight after reset
    resp_ready = 2'b11;
    set_port(0, 32'd10, 32'd3, C_SUB);
    set_port(1, 32'hFF, 32'h0F, C_XOR);
    grants = 0; last_cyc = -1; expp = 0;
    for (int k = 0; k < 40 && grants < 4; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        chk("tie_grant", 32'(req_ready), (expp == 0) ? 32'h1 : 32'h2);
        e.p = expp[0]; e.d = (expp == 0) ? 32'h7 : 32'hF0;
        q.push_back(e);
        if (last_cyc >= 0) chk("tie_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        expp ^= 1;
        grants++;
      end
    end
    chk("tie_grant_count", 32'(grants), 32'd4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Single op with exact latency
    @(posedge clk); #1;
    e.p = 1'b0; e.d = 32'h8;
    q.push_back(e);
    set_port(0, 32'h5, 32'h3, C_ADD);
    @(negedge clk);
    chk("single_ready_same_cycle", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_exec_no_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_data", resp_data, 32'h8);
    drain();

    // Backpressure on port1
    @(posedge clk); #1;
    resp_ready = 2'b00;
    do_req(1, 32'h1, 32'h24, C_SLL, 1'b1, 32'h10);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h2);
      chk("bp_resp_data", resp_data, 32'h10);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_busy", 32'(busy), 32'h0);
    chk("bp_done_valid", 32'(resp_valid), 32'h0);
    chk("bp_queue_empty", 32'(q.size()), 32'h0);

    // Wrap and compare edge cases
    @(posedge clk); #1;
    resp_ready = 2'b11;
    do_req(0, 32'hFFFF_FFFF, 32'h1, C_ADD, 1'b1, 32'h0);
    do_req(1, 32'h8000_0000, 32'h1, C_SLT, 1'b1, 32'h0);
    do_req(0, 32'h8000_0000, 32'd31, C_SRL, 1'b1, 32'h1);
    do_req(1, 32'h3, 32'h8000_0000, C_SLT, 1'b1, 32'h1);
    drain();

    // Reset while a response is pending
    @(posedge clk); #1;
    resp_ready = 2'b00;
    do_req(0, 32'h1, 32'h2, C_ADD, 1'b0, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid == 2'b01) begin ok = 1'b1; break; end
    end
    chk("rst_reached_resp", 32'(ok), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_port(0, 32'h7, 32'h1, C_ADD);
    @(negedge clk);
    chk("rst_cycle_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    e.p = 1'b0; e.d = 32'h8;
    q.push_back(e);
    @(negedge clk);
    chk("rst_after_valid", 32'(resp_valid), 32'h0);
    chk("rst_after_busy", 32'(busy), 32'h0);
    chk("rst_after_data", resp_data, 32'h0);
    chk("rst_after_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    drain();

    // Undefined ALU code
    @(posedge clk); #1;
    do_req(1, 32'h1234, 32'h5678, C_BAD, 1'b1, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares one `ALU` instance between two requesters, e.g. a main-pipeline client and a secondary client such as an address-generation or debug unit. Each requester submits an operand pair and ALU code through a valid/ready handshake. The block grants requests round-robin, latches the operands, and drives the shared ALU for one cycle. It registers the result and returns it on a per-port response channel with backpressure. The block sits between the requesters and the ALU; the ALU stays purely combinational inside it.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width, equal to the `DataPath` width.
- `CODE_WIDTH`, 4: ALU code width, equal to the `ALUCodePath` width.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid[1:0]`  in  2: request valid, bit i = port i.
- `req_ready[1:0]`  out  2: request accepted this cycle when valid & ready.
- `req_a0`, `req_a1`  in  DATA_WIDTH: operand A per port.
- `req_b0`, `req_b1`  in  DATA_WIDTH: operand B per port.
- `req_code0`, `req_code1`  in  CODE_WIDTH: ALU code per port.
- `resp_valid[1:0]`  out  2: result valid for port i.
- `resp_ready[1:0]`  in  2: port i consumes result.
- `resp_data`  out  DATA_WIDTH: result, meaningful only while a `resp_valid` bit is set.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - Grant is combinational.
  - If exactly one `req_valid` bit is set, that port wins.
  - If both are set, the port not equal to `last_grant` wins.
  - `req_ready[g]` = 1 only for the winner; the other bit is 0.
  - On handshake: latch A, B, code and owner (g); set `last_grant`=g; go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC:**
  - Latched operands drive the ALU.
  - ALU output is registered into `resp_data`; go to RESP.
  - `req_ready` = 0.
- **RESP:**
  - `resp_valid[owner]`=1; the other bit is 0.
  - On `resp_ready[owner]`=1, return to IDLE.
  - `resp_ready` on the non-owner port is ignored.
- **ALU codes:**
  - SLL, SRL: shift amount = B[4:0]; SRL is logical.
  - ADD, SUB: modulo 2^DATA_WIDTH, no flags.
  - OR, XOR, AND: bitwise.
  - SLT: unsigned compare (A<B → 1, else 0), zero-extended.
  - An undefined code registers 0 (no latch, no X).
- **Sharing rules:**
  - One operation in flight at a time.
  - A request is never dropped or duplicated.
  - A requester must hold valid/A/B/code stable until ready.
- **Reset values:**
  - `req_ready`=0.
  - `resp_valid`=0, `resp_data`=0, `busy`=0.
  - `last_grant`=1, so port 0 wins the first tie.

## Timing
- Request handshake in cycle N; EXEC in N+1; `resp_valid` high from N+2.
- Minimum turnaround is 3 cycles per operation: the earliest next `req_ready` is N+3 if the response is consumed in N+2.
- `resp_valid` and `resp_data` stay stable while `resp_ready`=0, for unbounded cycles.
- `req_ready` is 0 in EXEC and RESP, and also during the cycle of `rst`.
- Reset mid-operation (EXEC or RESP): next cycle is IDLE with all outputs at reset values. The pending result is discarded, and the requester must re-issue.
- `resp_ready` asserted before `resp_valid` has no effect.

## Test plan
- **Single op:** port0 issues ADD A=0x0000_0005, B=0x0000_0003. Expected: `req_ready[0]` in the same cycle, `resp_valid`=2'b01 two cycles later, `resp_data`=0x0000_0008.
- **Tie fairness after reset:** both ports hold valid (port0 SUB 10−3, port1 XOR 0xFF^0x0F) with `resp_ready` tied high. Expected grant order port0, port1, port0…, results 0x7 then 0xF0, one grant every 3 cycles.
- **Backpressure:** port1 SLL A=1, B=0x24 (shift 4) with `resp_ready[1]`=0 for 5 cycles. Expected: `resp_valid`=2'b10 and `resp_data`=0x10 stable for all 5 cycles, `req_ready`=0 throughout, completion on the cycle `resp_ready[1]` rises.
- **Wrap and compare:** ADD 0xFFFF_FFFF+1 gives 0. SLT 0x8000_0000 < 1 gives 0 (unsigned). SRL 0x8000_0000 by 31 gives 1.
- **Reset during RESP:** assert `rst` for one cycle while `resp_valid`=1. Expected: `resp_valid`=0 and `busy`=0 the next cycle; a subsequent port0 request is accepted immediately.
- **Undefined code:** an undefined code with A=0x1234, B=0x5678. Expected: `resp_data`=0, handshake completes normally.
